// File: rtl/stage_if_fetch_unit.sv
// rtl/stage_if_fetch_unit.sv - instruction fetch producer for the IF/ID register; optional FETCH_STALL_CNT_EN stall counter
module stage_if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    // Low for the first cycle after reset release so no request goes out
    // while reset is (or has just been) asserted.
    logic        run;
    logic [31:0] pc_next;

    assign pc_next = pc + STEP;

    // Fetch FSM: PC update, hold buffer capture and redirect handling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            buf_instr <= 32'h0;
            buf_pc    <= 32'h0;
            run       <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) begin
                case (state)
                    S_REQ: begin
                        // Remember the address on the bus so an unabortable
                        // request can keep being presented after a redirect.
                        req_addr <= pc;
                        if (branch_taken) begin
                            pc    <= branch_address;
                            state <= imem_ready ? S_REQ : S_DRAIN;
                        end else if (imem_ready) begin
                            pc <= pc_next;
                            if (freeze) begin
                                buf_instr <= imem_rdata;
                                buf_pc    <= pc_next;
                                state     <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (branch_taken) begin
                            pc    <= branch_address;
                            state <= S_REQ;
                        end else if (!freeze) begin
                            state <= S_REQ;
                        end
                    end
                    S_DRAIN: begin
                        if (branch_taken) begin
                            pc <= branch_address;
                        end
                        if (imem_ready) begin
                            state <= S_REQ;
                        end
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end

    // Request and presentation outputs; REQ forwards memory data with no latency.
    always_comb begin
        imem_req        = 1'b0;
        imem_addr       = pc;
        valid_out       = 1'b0;
        pc_out          = 32'h0;
        instruction_out = 32'h0;
        case (state)
            S_REQ: begin
                imem_req  = run;
                imem_addr = pc;
                if (run && imem_ready) begin
                    valid_out       = 1'b1;
                    pc_out          = pc_next;
                    instruction_out = imem_rdata;
                end
            end
            S_HOLD: begin
                valid_out       = 1'b1;
                pc_out          = buf_pc;
                instruction_out = buf_instr;
            end
            S_DRAIN: begin
                imem_req  = run;
                imem_addr = req_addr;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

`ifdef FETCH_STALL_CNT_EN
    // Count cycles that deliver no new instruction: memory waits and holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= 32'h0;
        end else if (run && ((state == S_HOLD) || !imem_ready)) begin
            stall_cycles <= stall_cycles + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_stage_if_fetch_unit.sv
// tb/tb_stage_if_fetch_unit.sv - self-checking bench for stage_if_fetch_unit
module tb_stage_if_fetch_unit;

    typedef struct {
        logic        rdy;
        logic        frz;
        logic        br;
        logic [31:0] baddr;
        logic        ereq;
        logic        chk_addr;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
        logic [31:0] eia;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, frz1, br1, rdy1;
    logic [31:0] baddr1;
    logic        req1, val1;
    logic [31:0] addr1, rdata1, pco1, ins1;

    logic        rst2, frz2, br2, rdy2;
    logic [31:0] baddr2;
    logic        req2, val2;
    logic [31:0] addr2, rdata2, pco2, ins2;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall1, stall2;
`endif

    int checks   = 0;
    int failures = 0;
    int sel      = 0;
    exp_t sb[$];

    vec_t va[24];
    vec_t vb[10];

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A00_00A5;
    endfunction

    assign rdata1 = tag(addr1);
    assign rdata2 = tag(addr2);

    stage_if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut1 (
        .clk(clk), .rst(rst1), .freeze(frz1), .branch_taken(br1),
        .branch_address(baddr1), .imem_req(req1), .imem_addr(addr1),
        .imem_ready(rdy1), .imem_rdata(rdata1), .valid_out(val1),
        .pc_out(pco1), .instruction_out(ins1)
`ifdef FETCH_STALL_CNT_EN
        , .stall_cycles(stall1)
`endif
    );

    stage_if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut2 (
        .clk(clk), .rst(rst2), .freeze(frz2), .branch_taken(br2),
        .branch_address(baddr2), .imem_req(req2), .imem_addr(addr2),
        .imem_ready(rdy2), .imem_rdata(rdata2), .valid_out(val2),
        .pc_out(pco2), .instruction_out(ins2)
`ifdef FETCH_STALL_CNT_EN
        , .stall_cycles(stall2)
`endif
    );

    function automatic vec_t mk(input logic rdy, input logic frz, input logic br,
                                input logic [31:0] baddr, input logic ereq,
                                input logic chk_addr, input logic [31:0] eaddr,
                                input logic evalid, input logic [31:0] epc,
                                input logic [31:0] eia);
        vec_t v;
        v.rdy = rdy; v.frz = frz; v.br = br; v.baddr = baddr;
        v.ereq = ereq; v.chk_addr = chk_addr; v.eaddr = eaddr;
        v.evalid = evalid; v.epc = epc; v.eia = eia;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        exp_t got;
        logic        o_req, o_val;
        logic [31:0] o_addr, o_pc, o_ins;
        if (sel == 0) begin
            rdy1 = v.rdy; frz1 = v.frz; br1 = v.br; baddr1 = v.baddr;
        end else begin
            rdy2 = v.rdy; frz2 = v.frz; br2 = v.br; baddr2 = v.baddr;
        end
        if (v.evalid) begin
            e.pc    = v.epc;
            e.instr = tag(v.eia);
            sb.push_back(e);
        end
        @(negedge clk);
        o_req  = (sel == 0) ? req1  : req2;
        o_val  = (sel == 0) ? val1  : val2;
        o_addr = (sel == 0) ? addr1 : addr2;
        o_pc   = (sel == 0) ? pco1  : pco2;
        o_ins  = (sel == 0) ? ins1  : ins2;
        chk({name, ".req"}, {31'h0, o_req}, {31'h0, v.ereq});
        if (v.chk_addr) chk({name, ".addr"}, o_addr, v.eaddr);
        chk({name, ".valid"}, {31'h0, o_val}, {31'h0, v.evalid});
        if (o_val) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s.unexpected_valid: got pc %h expected no output", name, o_pc);
            end else begin
                got = sb.pop_front();
                chk({name, ".pc_out"}, o_pc, got.pc);
                chk({name, ".instr"}, o_ins, got.instr);
            end
        end else begin
            if (v.evalid && sb.size() != 0) void'(sb.pop_back());
            chk({name, ".bubble_pc"}, o_pc, 32'h0);
            chk({name, ".bubble_instr"}, o_ins, 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stream, waits, freeze, branches, redirect corner cases on dut1
        va[0]  = mk(1,0,0,0,        1,1,32'h0,   1,32'h4,   32'h0);
        va[1]  = mk(1,0,0,0,        1,1,32'h4,   1,32'h8,   32'h4);
        va[2]  = mk(0,0,0,0,        1,1,32'h8,   0,0,0);
        va[3]  = mk(0,0,0,0,        1,1,32'h8,   0,0,0);
        va[4]  = mk(0,0,0,0,        1,1,32'h8,   0,0,0);
        va[5]  = mk(1,0,0,0,        1,1,32'h8,   1,32'hC,   32'h8);
        va[6]  = mk(1,1,0,0,        1,1,32'hC,   1,32'h10,  32'hC);
        va[7]  = mk(0,1,0,0,        0,0,0,       1,32'h10,  32'hC);
        va[8]  = mk(0,0,0,0,        0,0,0,       1,32'h10,  32'hC);
        va[9]  = mk(1,0,0,0,        1,1,32'h10,  1,32'h14,  32'h10);
        va[10] = mk(0,0,1,32'h100,  1,1,32'h14,  0,0,0);
        va[11] = mk(0,0,0,0,        1,1,32'h14,  0,0,0);
        va[12] = mk(1,0,0,0,        1,1,32'h14,  0,0,0);
        va[13] = mk(1,0,0,0,        1,1,32'h100, 1,32'h104, 32'h100);
        va[14] = mk(1,1,0,0,        1,1,32'h104, 1,32'h108, 32'h104);
        va[15] = mk(0,1,1,32'h40,   0,0,0,       1,32'h108, 32'h104);
        va[16] = mk(0,0,0,0,        1,1,32'h40,  0,0,0);
        va[17] = mk(1,0,0,0,        1,1,32'h40,  1,32'h44,  32'h40);
        va[18] = mk(1,1,1,32'h200,  1,1,32'h44,  1,32'h48,  32'h44);
        va[19] = mk(1,0,0,0,        1,1,32'h200, 1,32'h204, 32'h200);
        va[20] = mk(0,0,1,32'h300,  1,1,32'h204, 0,0,0);
        va[21] = mk(0,0,1,32'h400,  1,1,32'h204, 0,0,0);
        va[22] = mk(1,0,0,0,        1,1,32'h204, 0,0,0);
        va[23] = mk(1,0,0,0,        1,1,32'h400, 1,32'h404, 32'h400);
        // wrap and stall accounting on dut2
        vb[0] = mk(1,0,0,0, 1,1,32'hFFFF_FFF8, 1,32'hFFFF_FFFC, 32'hFFFF_FFF8);
        vb[1] = mk(1,0,0,0, 1,1,32'hFFFF_FFFC, 1,32'h0,         32'hFFFF_FFFC);
        vb[2] = mk(1,0,0,0, 1,1,32'h0,         1,32'h4,         32'h0);
        vb[3] = mk(0,0,0,0, 1,1,32'h4,         0,0,0);
        vb[4] = mk(0,0,0,0, 1,1,32'h4,         0,0,0);
        vb[5] = mk(0,0,0,0, 1,1,32'h4,         0,0,0);
        vb[6] = mk(1,1,0,0, 1,1,32'h4,         1,32'h8,         32'h4);
        vb[7] = mk(0,1,0,0, 0,0,0,             1,32'h8,         32'h4);
        vb[8] = mk(0,0,0,0, 0,0,0,             1,32'h8,         32'h4);
        vb[9] = mk(1,0,0,0, 1,1,32'h8,         1,32'hC,         32'h8);

        rst1 = 1'b0; frz1 = 1'b0; br1 = 1'b0; rdy1 = 1'b1; baddr1 = 32'h0;
        rst2 = 1'b0; frz2 = 1'b0; br2 = 1'b0; rdy2 = 1'b0; baddr2 = 32'h0;

        #2;
        chk("reset.req",   {31'h0, req1}, 32'h0);
        chk("reset.valid", {31'h0, val1}, 32'h0);
        chk("reset.pc",    pco1, 32'h0);
        chk("reset.instr", ins1, 32'h0);
`ifdef FETCH_STALL_CNT_EN
        chk("reset.stall", stall1, 32'h0);
`endif
        @(posedge clk); @(posedge clk); #1;
        rst1 = 1'b1;
        #1;
        chk("release.req",   {31'h0, req1}, 32'h0);
        chk("release.valid", {31'h0, val1}, 32'h0);
        @(posedge clk); #1;

        sel = 0;
        for (int i = 0; i < 24; i++) apply(va[i], $sformatf("main%0d", i));
        chk("main.sb_empty", sb.size(), 32'h0);
`ifdef FETCH_STALL_CNT_EN
        chk("main.stall", stall1, 32'd11);
`endif

        // reset while a request is pending
        rdy1 = 1'b0;
        #2;
        rst1 = 1'b0;
        #1;
        chk("midrst.req", {31'h0, req1}, 32'h0);
        rdy1 = 1'b1;
        #1;
        chk("midrst.valid", {31'h0, val1}, 32'h0);
        chk("midrst.instr", ins1, 32'h0);
        @(posedge clk); #1;
        rst1 = 1'b1;
        rdy1 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst.req_after", {31'h0, req1}, 32'h1);
        chk("midrst.addr_after", addr1, 32'h0);
        @(posedge clk); #1;

        rst2 = 1'b1;
        rdy2 = 1'b1;
        @(posedge clk); #1;
        sel = 1;
        for (int i = 0; i < 10; i++) apply(vb[i], $sformatf("wrap%0d", i));
        chk("wrap.sb_empty", sb.size(), 32'h0);
`ifdef FETCH_STALL_CNT_EN
        chk("wrap.stall", stall2, 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
